// File: rtl/bus_periph_pkg.sv
// Shared constants and types for the memory-mapped peripheral block:
// address window, register indices, TCON bit positions and UART states.
package bus_periph_pkg;

  localparam logic [31:0] BASE_ADDR = 32'h4000_0000;
  localparam logic [26:0] BASE_HI   = 27'h200_0000;

  localparam logic [2:0] REG_TH       = 3'd0;
  localparam logic [2:0] REG_TL       = 3'd1;
  localparam logic [2:0] REG_TCON     = 3'd2;
  localparam logic [2:0] REG_LED      = 3'd3;
  localparam logic [2:0] REG_DIGI     = 3'd4;
  localparam logic [2:0] REG_SYSTICK  = 3'd5;
  localparam logic [2:0] REG_UART_TXD = 3'd6;
  localparam logic [2:0] REG_UART_CON = 3'd7;

  localparam int TCON_EN = 0;
  localparam int TCON_IE = 1;
  localparam int TCON_IS = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_t;

endpackage

// File: rtl/bus_peripherals_uart_tx.sv
// 8N1 serial transmitter, LSB first; tx is driven straight from a register.
module uart_tx
  import bus_periph_pkg::*;
#(
  parameter int CLK_DIV = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       busy,
  output logic       done_pulse,
  output logic       tx
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  uart_state_t      state_r, state_s;
  logic [DIV_W-1:0] div_r, div_s;
  logic [2:0]       bit_r, bit_s;
  logic [7:0]       shift_r, shift_s;
  logic             tx_r, tx_s;
  logic             busy_r, busy_s;
  logic             div_end_s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      div_r   <= {DIV_W{1'b0}};
      bit_r   <= 3'd0;
      shift_r <= 8'h00;
      tx_r    <= 1'b1;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      div_r   <= div_s;
      bit_r   <= bit_s;
      shift_r <= shift_s;
      tx_r    <= tx_s;
      busy_r  <= busy_s;
    end
  end

  // Each state lasts CLK_DIV cycles; the shift register feeds the next bit.
  always_comb begin
    state_s    = state_r;
    div_s      = div_r;
    bit_s      = bit_r;
    shift_s    = shift_r;
    tx_s       = tx_r;
    busy_s     = busy_r;
    done_pulse = 1'b0;
    div_end_s  = (div_r == DIV_LAST);
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s = ST_START;
          div_s   = {DIV_W{1'b0}};
          shift_s = data;
          tx_s    = 1'b0;
          busy_s  = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (div_end_s) begin
          state_s = ST_DATA;
          div_s   = {DIV_W{1'b0}};
          bit_s   = 3'd0;
          tx_s    = shift_r[0];
          shift_s = {1'b0, shift_r[7:1]};
        end else begin
          div_s = div_r + DIV_W'(1);
        end
      end
      ST_DATA: begin
        if (div_end_s) begin
          div_s = {DIV_W{1'b0}};
          if (bit_r == 3'd7) begin
            state_s = ST_STOP;
            tx_s    = 1'b1;
          end else begin
            bit_s   = bit_r + 3'd1;
            tx_s    = shift_r[0];
            shift_s = {1'b0, shift_r[7:1]};
          end
        end else begin
          div_s = div_r + DIV_W'(1);
        end
      end
      ST_STOP: begin
        if (div_end_s) begin
          state_s    = ST_IDLE;
          div_s      = {DIV_W{1'b0}};
          busy_s     = 1'b0;
          done_pulse = 1'b1;
        end else begin
          div_s = div_r + DIV_W'(1);
        end
      end
      default: begin
        state_s = ST_IDLE;
        tx_s    = 1'b1;
        busy_s  = 1'b0;
      end
    endcase
  end

  assign busy = busy_r;
  assign tx   = tx_r;

endmodule

// File: rtl/bus_peripherals.sv
// Peripheral block at 0x4000_0000..0x4000_001F: reloadable timer with irq,
// LED/DIGI outputs, free-running SYSTICK and a UART transmitter.
module bus_peripherals
  import bus_periph_pkg::*;
#(
  parameter int CLK_DIV = 868
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] MemBus_Address,
  input  logic [31:0] MemBus_Write_Data,
  output logic [31:0] Device_Read_Data,
  output logic [7:0]  leds,
  output logic [11:0] digi,
  output logic        irq,
  output logic        uart_tx
);

  logic        hit_s, wr_s, tl_ovf_s, tx_accept_s, unused_s;
  logic [2:0]  idx_s;
  logic [31:0] th_r, tl_r, systick_r, rdata_s;
  logic [2:0]  tcon_r;
  logic [7:0]  led_r, txd_r;
  logic [11:0] digi_r;
  logic        start_r, done_r, busy_s, done_pulse_s;

  assign hit_s    = (MemBus_Address[31:5] == BASE_HI);
  assign idx_s    = MemBus_Address[4:2];
  assign wr_s     = MemWrite & hit_s;
  assign unused_s = &{1'b0, MemBus_Address[1:0]};
  assign tl_ovf_s = tcon_r[TCON_EN] & (tl_r == 32'hFFFF_FFFF);
  // The finishing cycle of a frame already counts as idle; a pending start blocks.
  assign tx_accept_s = wr_s & (idx_s == REG_UART_TXD) & (~busy_s | done_pulse_s) & ~start_r;

  // Bus writes to TL/TCON take priority over the timer's own update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      th_r   <= 32'h0;
      tl_r   <= 32'h0;
      tcon_r <= 3'b000;
    end else begin
      if (wr_s && idx_s == REG_TH) th_r <= MemBus_Write_Data;
      if (wr_s && idx_s == REG_TL) tl_r <= MemBus_Write_Data;
      else if (tl_ovf_s)           tl_r <= th_r;
      else if (tcon_r[TCON_EN])    tl_r <= tl_r + 32'd1;
      if (wr_s && idx_s == REG_TCON)         tcon_r <= MemBus_Write_Data[2:0];
      else if (tl_ovf_s && tcon_r[TCON_IE])  tcon_r[TCON_IS] <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_r     <= 8'h00;
      digi_r    <= 12'h000;
      systick_r <= 32'h0;
      txd_r     <= 8'h00;
      start_r   <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      systick_r <= systick_r + 32'd1;
      if (wr_s && idx_s == REG_LED)  led_r  <= MemBus_Write_Data[7:0];
      if (wr_s && idx_s == REG_DIGI) digi_r <= MemBus_Write_Data[11:0];
      if (tx_accept_s) txd_r <= MemBus_Write_Data[7:0];
      start_r <= tx_accept_s;
      if (done_pulse_s)                         done_r <= 1'b1;
      else if (wr_s && idx_s == REG_UART_CON)   done_r <= 1'b0;
    end
  end

  uart_tx #(.CLK_DIV(CLK_DIV)) u_uart_tx (
    .clk        (clk),
    .reset      (reset),
    .start      (start_r),
    .data       (txd_r),
    .busy       (busy_s),
    .done_pulse (done_pulse_s),
    .tx         (uart_tx)
  );

  always_comb begin
    rdata_s = 32'h0;
    if (MemRead && hit_s) begin
      case (idx_s)
        REG_TH:       rdata_s = th_r;
        REG_TL:       rdata_s = tl_r;
        REG_TCON:     rdata_s = {29'h0, tcon_r};
        REG_LED:      rdata_s = {24'h0, led_r};
        REG_DIGI:     rdata_s = {20'h0, digi_r};
        REG_SYSTICK:  rdata_s = systick_r;
        REG_UART_TXD: rdata_s = {24'h0, txd_r};
        REG_UART_CON: rdata_s = {30'h0, done_r, busy_s};
        default:      rdata_s = 32'h0;
      endcase
    end else begin
      rdata_s = 32'h0;
    end
  end

  assign Device_Read_Data = rdata_s;
  assign leds = led_r;
  assign digi = digi_r;
  assign irq  = tcon_r[TCON_IS];

endmodule
